// File: rtl/sound_arbiter.sv
// -----------------------------------------------------------------------------
// sound_arbiter
// Shares one piezo buzzer among four game sound sources: paddle hit, wall
// bounce, score and game over. Rising edges of the requests are granted by
// fixed priority (over > score > wall > paddle), and each grant plays one
// square-wave tone for a fixed number of video frames, followed by an optional
// silent gap. A higher-priority event preempts the tone now playing. One
// lower-priority event can wait in a single pending slot.
//
// Ports
//   clk         system clock
//   reset       asynchronous reset, active low
//   enable      1 = sound on; 0 = mute, flush pending, return to IDLE
//   frame_tick  one-cycle pulse per video frame
//   req_paddle  paddle-collision request (level or pulse)
//   req_wall    wall-collision request
//   req_score   score event request
//   req_over    game-over request
//   buzzer      square-wave drive to the piezo
//   busy        1 while a tone or the gap after it is in progress
//   active_id   tone now playing: 0 none, 1 paddle, 2 wall, 3 score, 4 over
//   grant       one-cycle pulse when a tone starts (including preemption)
// -----------------------------------------------------------------------------
module sound_arbiter #(
   parameter int unsigned DIV_PADDLE = 100000,
   parameter int unsigned DIV_WALL   = 50000,
   parameter int unsigned DIV_SCORE  = 25000,
   parameter int unsigned DIV_OVER   = 16667,
   parameter int unsigned DUR_PADDLE = 6,
   parameter int unsigned DUR_WALL   = 6,
   parameter int unsigned DUR_SCORE  = 20,
   parameter int unsigned DUR_OVER   = 60,
   parameter int unsigned GAP_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic       req_paddle,
   input  logic       req_wall,
   input  logic       req_score,
   input  logic       req_over,
   output logic       buzzer,
   output logic       busy,
   output logic [2:0] active_id,
   output logic       grant
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam logic [16:0] DIV_P = 17'(DIV_PADDLE);
   localparam logic [16:0] DIV_W = 17'(DIV_WALL);
   localparam logic [16:0] DIV_S = 17'(DIV_SCORE);
   localparam logic [16:0] DIV_O = 17'(DIV_OVER);
   localparam logic [7:0]  DUR_P = 8'(DUR_PADDLE);
   localparam logic [7:0]  DUR_W = 8'(DUR_WALL);
   localparam logic [7:0]  DUR_S = 8'(DUR_SCORE);
   localparam logic [7:0]  DUR_O = 8'(DUR_OVER);
   localparam logic [7:0]  GAP_N = 8'(GAP_FRAMES);

   // Request masks use bit (id-1): bit0 paddle ... bit3 over.
   function automatic logic [2:0] hi_id(input logic [3:0] m);
      if (m[3])      return 3'd4;
      else if (m[2]) return 3'd3;
      else if (m[1]) return 3'd2;
      else if (m[0]) return 3'd1;
      else           return 3'd0;
   endfunction

   function automatic logic [3:0] id_mask(input logic [2:0] id);
      case (id)
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0100;
         3'd4:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [16:0] div_of(input logic [2:0] id);
      case (id)
         3'd2:    return DIV_W;
         3'd3:    return DIV_S;
         3'd4:    return DIV_O;
         default: return DIV_P;
      endcase
   endfunction

   function automatic logic [7:0] dur_of(input logic [2:0] id);
      case (id)
         3'd2:    return DUR_W;
         3'd3:    return DUR_S;
         3'd4:    return DUR_O;
         default: return DUR_P;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  req_q;
   logic [16:0] div_q, div_d;
   logic [7:0]  dur_q, dur_d;
   logic [7:0]  gap_q, gap_d;
   logic [2:0]  act_q, act_d;
   logic [2:0]  pend_q, pend_d;
   logic        buzz_q, buzz_d;
   logic        grant_q, grant_d;

   logic [3:0]  req_now;
   logic [3:0]  ev;
   logic [3:0]  pmask;
   logic [3:0]  pool;
   logic [2:0]  ev_id;
   logic [2:0]  start_id;

   assign req_now = {req_over, req_score, req_wall, req_paddle};
   assign ev      = req_now & ~req_q;
   assign pmask   = id_mask(pend_q);
   assign ev_id   = hi_id(ev);

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      dur_d    = dur_q;
      gap_d    = gap_q;
      act_d    = act_q;
      pend_d   = pend_q;
      buzz_d   = buzz_q;
      grant_d  = 1'b0;
      start_id = 3'd0;
      pool     = 4'b0000;

      case (state_q)
         IDLE: begin
            if (ev != 4'b0000) begin
               start_id = ev_id;
               pend_d   = hi_id(ev & ~id_mask(ev_id));
            end
         end
         PLAY: begin
            if (div_q == div_of(act_q) - 17'd1) begin
               buzz_d = ~buzz_q;
               div_d  = 17'd0;
            end else begin
               div_d = div_q + 17'd1;
            end
            if (frame_tick && dur_q == 8'd1) begin
               // Tone over: silence first, then the gap or the next tone.
               buzz_d = 1'b0;
               act_d  = 3'd0;
               div_d  = 17'd0;
               dur_d  = 8'd0;
               if (GAP_FRAMES != 0) begin
                  state_d = GAP;
                  gap_d   = GAP_N;
                  pend_d  = hi_id(pmask | ev);
               end else begin
                  pool     = pmask | ev;
                  start_id = hi_id(pool);
                  pend_d   = hi_id(pool & ~id_mask(start_id));
                  if (start_id == 3'd0) state_d = IDLE;
               end
            end else begin
               if (frame_tick) dur_d = dur_q - 8'd1;
               if (ev_id > act_q) begin
                  // Preempt: the old tone is dropped, pending is kept.
                  start_id = ev_id;
                  pend_d   = hi_id(pmask | (ev & ~id_mask(ev_id)));
               end else begin
                  pend_d = hi_id(pmask | ev);
               end
            end
         end
         GAP: begin
            buzz_d = 1'b0;
            if (frame_tick && gap_q == 8'd1) begin
               gap_d    = 8'd0;
               pool     = pmask | ev;
               start_id = hi_id(pool);
               pend_d   = hi_id(pool & ~id_mask(start_id));
               if (start_id == 3'd0) state_d = IDLE;
            end else begin
               if (frame_tick) gap_d = gap_q - 8'd1;
               pend_d = hi_id(pmask | ev);
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_id != 3'd0) begin
         state_d = PLAY;
         grant_d = 1'b1;
         act_d   = start_id;
         dur_d   = dur_of(start_id);
         div_d   = 17'd0;
         buzz_d  = 1'b0;
      end

      if (!enable) begin
         state_d = IDLE;
         buzz_d  = 1'b0;
         act_d   = 3'd0;
         pend_d  = 3'd0;
         grant_d = 1'b0;
         div_d   = 17'd0;
         dur_d   = 8'd0;
         gap_d   = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= 4'b0000;
         div_q   <= 17'd0;
         dur_q   <= 8'd0;
         gap_q   <= 8'd0;
         act_q   <= 3'd0;
         pend_q  <= 3'd0;
         buzz_q  <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_now;
         div_q   <= div_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         buzz_q  <= buzz_d;
         grant_q <= grant_d;
      end
   end

   assign buzzer    = buzz_q;
   assign busy      = (state_q != IDLE);
   assign active_id = act_q;
   assign grant     = grant_q;

endmodule
